// File: rtl/sargantana_icache_pkg.sv
// Shared types and default widths for the I-cache refill path.
package sargantana_icache_pkg;

  localparam int ICACHE_PADDR_W = 40;
  localparam int ICACHE_LINE_W  = 128;
  localparam int ICACHE_BEAT_W  = 64;

  // Fill unit controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BEATS = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } fill_state_e;

  // Completed line handed back to the I-cache (ifill response).
  typedef struct packed {
    logic                      valid;
    logic [ICACHE_LINE_W-1:0]  data;
    logic [ICACHE_PADDR_W-1:0] paddr;
    logic                      err;
  } ifill_resp_t;

endpackage

// File: rtl/icache_fill_unit_if.sv
// Miss request, memory bus and fill response signals of the fill unit.
interface icache_fill_unit_if
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = ICACHE_PADDR_W,
  parameter int LINE_W  = ICACHE_LINE_W,
  parameter int BEAT_W  = ICACHE_BEAT_W
) ();

  // I-cache miss side
  logic               req_valid_i;
  logic [PADDR_W-1:0] req_paddr_i;
  logic               req_ready_o;
  logic               kill_i;

  // Memory request channel
  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [PADDR_W-1:0] mem_req_addr_o;

  // Memory response channel
  logic               mem_resp_valid_i;
  logic               mem_resp_last_i;
  logic               mem_resp_err_i;
  logic [BEAT_W-1:0]  mem_resp_data_i;

  // Fill response to the I-cache
  logic               fill_valid_o;
  logic [LINE_W-1:0]  fill_data_o;
  logic [PADDR_W-1:0] fill_paddr_o;
  logic               fill_err_o;

  // The fill unit itself.
  modport slave (
    input  req_valid_i, req_paddr_i, kill_i,
    input  mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_last_i, mem_resp_err_i, mem_resp_data_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o,
    output fill_valid_o, fill_data_o, fill_paddr_o, fill_err_o
  );

  // The cache / memory environment around the fill unit.
  modport master (
    output req_valid_i, req_paddr_i, kill_i,
    output mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_last_i, mem_resp_err_i, mem_resp_data_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o,
    input  fill_valid_o, fill_data_o, fill_paddr_o, fill_err_o
  );

endinterface

// File: rtl/icache_fill_unit.sv
// I-cache line fill unit: takes one miss at a time, issues a line-aligned
// memory request, assembles the returned beats into a line and hands the
// line back once. A kill abandons the fill and drains the memory response.
module icache_fill_unit
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = ICACHE_PADDR_W,
  parameter int LINE_W  = ICACHE_LINE_W,
  parameter int BEAT_W  = ICACHE_BEAT_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  icache_fill_unit_if.slave bus
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);

  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [PADDR_W-1:0] OFF_MASK  = PADDR_W'((1 << OFF_W) - 1);

  fill_state_e        state_q, state_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               kill_q, kill_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  line_q, line_d;

  // Kill seen at any point since the miss was captured, including this cycle.
  logic kill_seen;
  // A beat arrives while assembling the line.
  logic beat_fire;
  // That beat closes the assembly: tagged last, or the buffer is full.
  logic beat_final;
  // The response stream ends with this beat.
  logic resp_last;

  logic               req_ready;
  logic               mem_req_valid;
  logic [PADDR_W-1:0] mem_req_addr;
  ifill_resp_t        fill_resp;

  assign kill_seen  = kill_q | bus.kill_i;
  assign resp_last  = bus.mem_resp_valid_i & bus.mem_resp_last_i;
  assign beat_fire  = (state_q == BEATS) & bus.mem_resp_valid_i;
  assign beat_final = beat_fire & (bus.mem_resp_last_i | (beat_cnt_q == LAST_BEAT));

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: the line buffer is reset explicitly; an early-last fill relies on
  // its unreceived slices reading as zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      beat_cnt_q <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      beat_cnt_q <= beat_cnt_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      line_q     <= line_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ready_i) state_d = kill_seen ? DRAIN : BEATS;
      end
      BEATS: begin
        if (beat_final) begin
          if (kill_seen)                state_d = bus.mem_resp_last_i ? IDLE : DRAIN;
          else if (bus.mem_resp_last_i) state_d = RESP;
          else                          state_d = DRAIN;  // buffer full, stream continues
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (resp_last) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address capture, kill/error tracking and beat assembly.
  always_comb begin
    paddr_d    = paddr_q;
    beat_cnt_d = beat_cnt_q;
    kill_d     = kill_q;
    err_d      = err_q;
    line_d     = line_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          paddr_d    = bus.req_paddr_i & ~OFF_MASK;
          beat_cnt_d = '0;
          kill_d     = 1'b0;
          err_d      = 1'b0;
          line_d     = '0;
        end
      end
      REQ: begin
        kill_d = kill_seen;
      end
      BEATS: begin
        kill_d = kill_seen;
        if (beat_fire) begin
          line_d[int'(beat_cnt_q) * BEAT_W +: BEAT_W] = bus.mem_resp_data_i;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // Bus error, short line (last too early) or overlong line (no last
          // on the final slot) all mark the fill as erroneous.
          err_d = err_q | bus.mem_resp_err_i
                | (bus.mem_resp_last_i  & (beat_cnt_q != LAST_BEAT))
                | (~bus.mem_resp_last_i & (beat_cnt_q == LAST_BEAT));
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    fill_resp     = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = paddr_q;
      end
      RESP: begin
        if (!bus.kill_i) begin
          fill_resp.valid = 1'b1;
          fill_resp.data  = line_q;
          fill_resp.paddr = paddr_q;
          fill_resp.err   = err_q;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready_o     = req_ready;
  assign bus.mem_req_valid_o = mem_req_valid;
  assign bus.mem_req_addr_o  = mem_req_addr;
  assign bus.fill_valid_o    = fill_resp.valid;
  assign bus.fill_data_o     = fill_resp.data;
  assign bus.fill_paddr_o    = fill_resp.paddr;
  assign bus.fill_err_o      = fill_resp.err;

endmodule

// File: doc/icache_fill_unit.md
ICACHE_FILL_UNIT -- requirements
Module: icache_fill_unit

Interface
REQ-001 SHALL have parameter PADDR_W, default 40, physical address width.
REQ-002 SHALL have parameter LINE_W, default 128, I-cache line width in bits.
REQ-003 SHALL have parameter BEAT_W, default 64, memory beat width; LINE_W/BEAT_W (NBEATS) is a power of two ≥2.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock.
REQ-005 SHALL have rstn_i  in  1  asynchronous active-low reset.
REQ-006 SHALL have req_valid_i  in  1  I-cache miss request valid.
REQ-007 SHALL have req_paddr_i  in  PADDR_W  miss physical address.
REQ-008 SHALL have req_ready_o  out  1  unit accepts a miss.
REQ-009 SHALL have kill_i  in  1  abandon the current fill (pipeline flush).
REQ-010 SHALL have mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
REQ-011 SHALL have mem_req_addr_o  out  PADDR_W  line-aligned request address.
REQ-012 SHALL have mem_resp_valid_i, mem_resp_last_i, mem_resp_err_i  in  1  beat valid, final beat, bus error.
REQ-013 SHALL have mem_resp_data_i  in  BEAT_W  beat data.
REQ-014 SHALL have fill_valid_o  out  1, fill_data_o  out  LINE_W, fill_paddr_o  out  PADDR_W, fill_err_o  out  1: completed line to the I-cache (ifill response).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, BEATS, RESP, DRAIN.
REQ-016 SHALL assert req_ready_o only in IDLE; req_valid_i&&req_ready_o captures paddr with low log2(LINE_W/8) bits cleared and moves to REQ.
REQ-017 SHALL hold mem_req_valid_o high and mem_req_addr_o stable throughout REQ until mem_req_ready_i; kill_i never drops mem_req_valid_o.
REQ-018 SHALL move REQ->BEATS on handshake, or REQ->DRAIN on handshake if kill_i was seen at any cycle since capture (sticky kill flag).
REQ-019 SHALL in BEATS write each valid beat into slice [beat_cnt*BEAT_W +: BEAT_W], beat 0 lowest, beat_cnt wrapping modulo NBEATS.
REQ-020 SHALL OR mem_resp_err_i of every beat into a sticky error flag cleared on capture.
REQ-021 SHALL leave BEATS when mem_resp_last_i accompanies a valid beat or beat_cnt reaches NBEATS-1: to RESP, or to DRAIN if kill seen and last not yet received, or to IDLE if kill seen and last received.
REQ-022 SHALL flag error when last arrives before beat NBEATS-1, zeroing unreceived slices; beats beyond NBEATS before last go to DRAIN with error.
REQ-023 SHALL in RESP assert fill_valid_o for exactly one cycle with data, aligned paddr and error, then return to IDLE; kill_i in RESP suppresses fill_valid_o.
REQ-024 SHALL in DRAIN consume beats without storing until mem_resp_last_i, then return to IDLE with no fill_valid_o.
REQ-025 SHALL give miss-to-fill latency of 1 (REQ) + handshake wait + NBEATS beat cycles + 1 (RESP), minimum NBEATS+2 cycles.
REQ-026 SHALL accept a new request no earlier than the cycle after RESP or DRAIN exit (no back-to-back overlap).

Reset
REQ-027 SHALL, on rstn_i low, immediately enter IDLE, clear beat_cnt, kill and error flags, line buffer, and drive req_ready_o=1 after release, all other outputs 0.
REQ-028 SHALL, on reset mid-fill, discard the fill without any fill_valid_o; outstanding memory beats are the memory side's concern.

Structure
REQ-029 SHALL take PADDR_W, LINE_W, BEAT_W defaults and the ifill response typedef from sargantana_icache_pkg; the FSM state enum is also defined there.
REQ-030 SHALL be a single module; the line buffer is inline, no sub-module.

Verification
REQ-031 SHALL cover: request paddr 0x80000_0104, ready immediate, beats 0x11..,0x22.. with last -> mem addr 0x80000_0100, fill_valid_o one cycle, data {0x22..,0x11..}, err 0.
REQ-032 SHALL cover: mem_req_ready_i held low 5 cycles with kill_i pulsed on cycle 2 -> request stays valid, then DRAIN, 2 beats consumed, no fill_valid_o, req_ready_o returns.
REQ-033 SHALL cover: mem_resp_err_i on beat 1 -> fill_valid_o with fill_err_o=1.
REQ-034 SHALL cover: last on beat 0 -> fill_err_o=1, upper slice zero.
REQ-035 SHALL cover: rstn_i low during BEATS -> outputs 0 asynchronously, no fill; after release new request completes normally.
REQ-036 SHALL cover: beats with 3-cycle gaps between valid -> fill data correct, latency NBEATS+2+gaps.
